// File: rtl/tone_gen_pkg.sv
// Shared constants for the buzzer tone generator: note and octave codes,
// middle-octave half-period table at 100 MHz, and FSM state encoding.
package tone_gen_pkg;

  localparam int HW     = 19;
  localparam int REF_HZ = 100_000_000;

  localparam logic [2:0] n_space = 3'd0;
  localparam logic [2:0] n_do    = 3'd1;
  localparam logic [2:0] n_re    = 3'd2;
  localparam logic [2:0] n_mi    = 3'd3;
  localparam logic [2:0] n_fa    = 3'd4;
  localparam logic [2:0] n_so    = 3'd5;
  localparam logic [2:0] n_la    = 3'd6;
  localparam logic [2:0] n_q1    = 3'd7;

  localparam longint HP_DO = 191113;
  localparam longint HP_RE = 170262;
  localparam longint HP_MI = 151685;
  localparam longint HP_FA = 143172;
  localparam longint HP_SO = 127551;
  localparam longint HP_LA = 113636;
  localparam longint HP_Q1 = 101239;

  localparam logic [1:0] oct_low  = 2'd0;
  localparam logic [1:0] oct_mid  = 2'd1;
  localparam logic [1:0] oct_high = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    TONE = 1'b1
  } state_t;

  // Middle-octave half-period in REF_HZ cycles; a rest has no period.
  function automatic longint base_hp(input logic [2:0] note);
    case (note)
      n_do:    return HP_DO;
      n_re:    return HP_RE;
      n_mi:    return HP_MI;
      n_fa:    return HP_FA;
      n_so:    return HP_SO;
      n_la:    return HP_LA;
      n_q1:    return HP_Q1;
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/tone_gen_note_period_lut.sv
// Combinational note/octave to half-period lookup. The whole table is built
// at elaboration, so hardware is just an 8-entry constant mux plus a shift.
module note_period_lut
  import tone_gen_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int HP_SHIFT = 0
) (
  input  logic [2:0]    note_num,
  input  logic [1:0]    octave,
  output logic [HW-1:0] half_period
);

  // Scales with the clock, identity at 100 MHz; shift and clamp to at least 1.
  function automatic logic [HW-1:0] scaled_hp(input logic [2:0] note);
    longint v;
    v = ((base_hp(note) * longint'(CLK_HZ)) / longint'(REF_HZ)) >>> HP_SHIFT;
    if (v < 64'sd1) v = 64'sd1;
    return v[HW-1:0];
  endfunction

  localparam logic [HW-1:0] HP_TAB [0:7] = '{
    scaled_hp(3'd0), scaled_hp(3'd1), scaled_hp(3'd2), scaled_hp(3'd3),
    scaled_hp(3'd4), scaled_hp(3'd5), scaled_hp(3'd6), scaled_hp(3'd7)
  };

  logic [HW-1:0] mid_hp;
  logic [HW-1:0] oct_hp;

  always_comb begin
    mid_hp = HP_TAB[note_num];
    case (octave)
      oct_low:  oct_hp = mid_hp << 1;
      oct_mid:  oct_hp = mid_hp;
      oct_high: oct_hp = mid_hp >> 1;
      default:  oct_hp = mid_hp;
    endcase
    // A one-cycle half shifted up an octave would reach 0 and wrap the counter.
    half_period = (oct_hp == '0) ? HW'(1) : oct_hp;
  end

endmodule

// File: rtl/tone_gen.sv
// Note-number to buzzer square wave. Pitch, octave and mute only change on
// full-period boundaries so the buzzer never sees a runt pulse.
//   state | meaning
//   IDLE  | silent, buzz low, waiting for en with a non-rest note
//   TONE  | playing cur_note; counter times the current half-period
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int HP_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] note_num,
  input  logic [1:0] octave,
  output logic       buzz,
  output logic       sounding,
  output logic [2:0] cur_note,
  output logic       period_done
);

  state_t        state;
  logic [HW-1:0] counter;
  logic [1:0]    oct_q;

  logic          reload_high;
  logic [2:0]    lut_note;
  logic [1:0]    lut_oct;
  logic [HW-1:0] half_period;
  logic          want_tone;

  // At the end of a high half the low half must reuse the latched pitch;
  // everywhere else the LUT looks at the live inputs for the next period.
  assign reload_high = (state == TONE) && buzz;
  assign lut_note    = reload_high ? cur_note : note_num;
  assign lut_oct     = reload_high ? oct_q    : octave;
  assign want_tone   = en && (note_num != n_space);

  note_period_lut #(
    .CLK_HZ   (CLK_HZ),
    .HP_SHIFT (HP_SHIFT)
  ) u_lut (
    .note_num    (lut_note),
    .octave      (lut_oct),
    .half_period (half_period)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buzz        <= 1'b0;
      cur_note    <= n_space;
      oct_q       <= oct_mid;
      counter     <= '0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      case (state)
        IDLE: begin
          if (want_tone) begin
            state    <= TONE;
            buzz     <= 1'b1;
            cur_note <= note_num;
            oct_q    <= octave;
            counter  <= half_period - HW'(1);
          end
        end
        TONE: begin
          if (counter != '0) begin
            counter <= counter - HW'(1);
          end else if (buzz) begin
            buzz    <= 1'b0;
            counter <= half_period - HW'(1);
          end else begin
            period_done <= 1'b1;
            if (want_tone) begin
              buzz     <= 1'b1;
              cur_note <= note_num;
              oct_q    <= octave;
              counter  <= half_period - HW'(1);
            end else begin
              state    <= IDLE;
              cur_note <= n_space;
              counter  <= '0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          buzz     <= 1'b0;
          cur_note <= n_space;
          counter  <= '0;
        end
      endcase
    end
  end

  assign sounding = (state == TONE);

endmodule
